// File: rtl/l1d_line_ctrl.sv
// l1d_line_ctrl: bus-side sequencer for the L1 data cache.
// Handles write-through, single read, line refill and dirty-line writeback
// by issuing single-beat 64-bit transfers on the BIU bus master handshake.
// Optional feature: define L1D_LINE_CTRL_TIMEOUT_EN to abort any bus beat
// that waits BUS_TIMEOUT cycles without bus_ack/bus_err (handled as bus_err).
module l1d_line_ctrl #(
  parameter int unsigned LINE_BEATS  = 16,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_through_req,
  input  logic        read_req,
  input  logic        read_line_req,
  input  logic        write_line_req,
  input  logic [3:0]  L1_size,
  input  logic [63:0] pa,
  input  logic [63:0] wt_data,
  output logic [63:0] line_data,
  output logic [10:0] addr_count,
  output logic        line_write,
  output logic        cache_entry_refill,
  output logic        trans_rdy,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [3:0]  bus_size,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  // Byte span of one line; the base address clears these offset bits of pa.
  localparam int unsigned LineBytes = LINE_BEATS * 8;
  localparam logic [63:0] LineMask  = 64'(LineBytes - 1);
  localparam logic [10:0] LastBeat  = 11'(LINE_BEATS - 1);
  localparam logic [3:0]  BeatSize  = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    SGL,
    LR_REQ,
    LR_WR,
    WB_RD,
    WB_WR,
    DONE,
    ERR
  } state_t;

  // Kind of transaction accepted in IDLE; kept until the next IDLE.
  typedef enum logic [1:0] {
    OP_RD,
    OP_WT,
    OP_LR,
    OP_WB
  } op_t;

  state_t      r_state;
  state_t      w_state_nxt;
  op_t         r_op;
  op_t         w_op_nxt;
  logic [63:0] r_pa;
  logic [3:0]  r_size;
  logic [63:0] r_wdata;
  logic [63:0] r_line_data;
  logic [10:0] r_count;
  logic [10:0] w_count_nxt;
  logic        w_load;
  logic        w_capture;
  logic        w_bus_req;
  logic        w_timeout;
  logic        w_fail;
  logic        w_ack;
  logic        w_last;
  logic [63:0] w_line_base;
  logic [63:0] w_beat_addr;

  // A beat is outstanding only in the three bus-wait states; derived from
  // the state register so an async reset drops bus_req immediately.
  assign w_bus_req = (r_state == SGL) || (r_state == LR_REQ) || (r_state == WB_WR);

  // bus_err beats bus_ack; a timeout only fires when neither arrived.
  assign w_fail = bus_err | w_timeout;
  assign w_ack  = bus_ack & ~bus_err;
  assign w_last = (r_count == LastBeat);

  assign w_line_base = r_pa & ~LineMask;
  assign w_beat_addr = w_line_base + {50'd0, r_count, 3'b000};

`ifdef L1D_LINE_CTRL_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(BUS_TIMEOUT - 1);

  logic [15:0] r_wait;

  // Wait counter: idles at zero whenever no beat is outstanding so every new
  // bus_req starts from zero, and counts each cycle a beat goes unanswered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait <= '0;
    end else if (!w_bus_req || bus_ack || bus_err || w_timeout) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + 16'd1;
    end
  end

  assign w_timeout = w_bus_req && !bus_ack && !bus_err && (r_wait == TimeoutLast);
`else
  assign w_timeout = 1'b0;
`endif

  // State register for the transaction sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus the beat counter and datapath load enables.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_count_nxt = r_count;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_count_nxt = '0;
        if (write_line_req) begin
          w_load      = 1'b1;
          w_op_nxt    = OP_WB;
          w_state_nxt = WB_RD;
        end else if (read_line_req) begin
          w_load      = 1'b1;
          w_op_nxt    = OP_LR;
          w_state_nxt = LR_REQ;
        end else if (write_through_req) begin
          w_load      = 1'b1;
          w_op_nxt    = OP_WT;
          w_state_nxt = SGL;
        end else if (read_req) begin
          w_load      = 1'b1;
          w_op_nxt    = OP_RD;
          w_state_nxt = SGL;
        end
      end
      SGL: begin
        if (w_fail) begin
          w_count_nxt = '0;
          w_state_nxt = ERR;
        end else if (w_ack) begin
          w_capture   = (r_op == OP_RD);
          w_state_nxt = DONE;
        end
      end
      LR_REQ: begin
        if (w_fail) begin
          w_count_nxt = '0;
          w_state_nxt = ERR;
        end else if (w_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = LR_WR;
        end
      end
      LR_WR: begin
        if (w_last) begin
          w_count_nxt = '0;
          w_state_nxt = DONE;
        end else begin
          w_count_nxt = r_count + 11'd1;
          w_state_nxt = LR_REQ;
        end
      end
      WB_RD: begin
        w_state_nxt = WB_WR;
      end
      WB_WR: begin
        if (w_fail) begin
          w_count_nxt = '0;
          w_state_nxt = ERR;
        end else if (w_ack) begin
          if (w_last) begin
            w_count_nxt = '0;
            w_state_nxt = DONE;
          end else begin
            w_count_nxt = r_count + 11'd1;
            w_state_nxt = WB_RD;
          end
        end
      end
      DONE: begin
        w_count_nxt = '0;
        w_state_nxt = IDLE;
      end
      ERR: begin
        w_count_nxt = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Transaction registers: request fields captured in IDLE so later changes
  // on the cache side are ignored; writeback data taken at the end of WB_RD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op        <= OP_RD;
      r_pa        <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      r_line_data <= '0;
      r_count     <= '0;
    end else begin
      r_op    <= w_op_nxt;
      r_count <= w_count_nxt;
      if (w_load) begin
        r_pa    <= pa;
        r_size  <= L1_size;
        r_wdata <= wt_data;
      end else if (r_state == WB_RD) begin
        r_wdata <= wt_data;
      end
      if (w_capture) begin
        r_line_data <= bus_rdata;
      end
    end
  end

  // Bus outputs are zero whenever no beat is outstanding.
  assign bus_req   = w_bus_req;
  assign bus_we    = w_bus_req && ((r_op == OP_WT) || (r_op == OP_WB));
  assign bus_addr  = !w_bus_req ? 64'd0 : ((r_state == SGL) ? r_pa : w_beat_addr);
  assign bus_size  = !w_bus_req ? 4'd0 : ((r_state == SGL) ? r_size : BeatSize);
  assign bus_wdata = bus_we ? r_wdata : 64'd0;

  // Cache-side outputs.
  assign line_data          = r_line_data;
  assign addr_count         = r_count;
  assign line_write         = (r_state == LR_WR);
  assign trans_rdy          = (r_state == DONE);
  assign cache_entry_refill = (r_state == DONE) && (r_op == OP_LR);
  assign bus_error          = (r_state == ERR);

endmodule
